uart_rx_sequencer: RTL and testbench

Sequences the UART receive datapath once the frame detector has declared a valid start bit. It counts oversampled baud ticks to sample each data bit, the optional parity bit and the stop bit at bit centre, then assembles the byte. It returns rx_done to the frame detector so the detector can re-arm, and it presents the received byte to the host through a hold-until-read handshake with error flags.

---
 rtl/uart_rx_sequencer.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: bit-centre sampling after start detect,
// byte assembly, parity/stop checks and hold-until-read host handshake.
module uart_rx_sequencer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_in_pos_edge,
  input  logic                 rx_data,
  input  logic                 start_detected,
  output logic                 rx_done,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid,
  input  logic                 rd_en,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 overrun,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TLAST = TW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] ILAST = IW'(DATA_BITS - 1);
  localparam logic          ODD   = (PARITY_ODD != 0);
  localparam logic          PEN   = (PARITY_EN != 0);

  state_t                 state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   pe_pend_q, pe_pend_d;
  logic                   fe_pend_q, fe_pend_d;
  logic [DATA_BITS-1:0]   byte_q, byte_d;
  logic                   valid_q, valid_d;
  logic                   fe_q, fe_d;
  logic                   pe_q, pe_d;
  logic                   ovr_q, ovr_d;
  logic                   bit_end;

  // last oversample tick of the current bit period
  assign bit_end = baud_in_pos_edge && (tick_q == TLAST);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_detected) state_d = S_DATA;
      S_DATA:   if (bit_end && idx_q == ILAST)
                  state_d = PEN ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (bit_end) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    rx_done = (state_q == S_DONE);
    busy    = (state_q != S_IDLE);
  end

  // sampling datapath: tick counter, bit index, shifter, pending flags
  always_comb begin
    tick_d    = tick_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    pe_pend_d = pe_pend_q;
    fe_pend_d = fe_pend_q;
    case (state_q)
      S_IDLE: begin
        if (start_detected) begin
          shift_d    = '0;
          shift_d[0] = rx_data;
          idx_d      = IW'(1);
          tick_d     = '0;
          pe_pend_d  = 1'b0;
          fe_pend_d  = 1'b0;
        end
      end
      S_DATA, S_PARITY, S_STOP: begin
        if (baud_in_pos_edge)
          tick_d = bit_end ? '0 : tick_q + TW'(1);
        if (bit_end) begin
          unique case (1'b1)
            state_q == S_DATA: begin
              shift_d[idx_q] = rx_data;
              idx_d          = idx_q + IW'(1);
            end
            state_q == S_PARITY:
              pe_pend_d = rx_data ^ (^shift_q) ^ ODD;
            state_q == S_STOP:
              fe_pend_d = ~rx_data;
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // host-side holding registers and read handshake
  always_comb begin
    byte_d  = byte_q;
    valid_d = valid_q;
    fe_d    = fe_q;
    pe_d    = pe_q;
    ovr_d   = ovr_q;
    if (state_q == S_DONE) begin
      byte_d  = shift_q;
      valid_d = 1'b1;
      fe_d    = fe_pend_q;
      pe_d    = pe_pend_q;
      ovr_d   = rd_en ? 1'b0 : (ovr_q | valid_q);
    end else if (rd_en && valid_q) begin
      valid_d = 1'b0;
      fe_d    = 1'b0;
      pe_d    = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  // datapath and host registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      pe_pend_q <= 1'b0;
      fe_pend_q <= 1'b0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      pe_pend_q <= pe_pend_d;
      fe_pend_q <= fe_pend_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_byte       = byte_q;
  assign rx_valid      = valid_q;
  assign framing_error = fe_q;
  assign parity_error  = pe_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer: 8N1 and 8E1 instances
// driven from one serial line with hand-computed expectations.
module tb_uart_rx_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, tick, rx;
  logic       start_n, start_p, rd_n, rd_p;
  logic       done_n, valid_n, fe_n, pe_n, ovr_n, busy_n;
  logic       done_p, valid_p, fe_p, pe_p, ovr_p, busy_p;
  logic [7:0] byte_n, byte_p;

  int nchk = 0;
  int nerr = 0;

  uart_rx_sequencer dut_n (
    .clk(clk), .reset(reset),
    .baud_in_pos_edge(tick), .rx_data(rx),
    .start_detected(start_n), .rx_done(done_n),
    .rx_byte(byte_n), .rx_valid(valid_n),
    .rd_en(rd_n), .framing_error(fe_n),
    .parity_error(pe_n), .overrun(ovr_n),
    .busy(busy_n)
  );

  uart_rx_sequencer #(
    .PARITY_EN(1), .PARITY_ODD(0)
  ) dut_p (
    .clk(clk), .reset(reset),
    .baud_in_pos_edge(tick), .rx_data(rx),
    .start_detected(start_p), .rx_done(done_p),
    .rx_byte(byte_p), .rx_valid(valid_p),
    .rd_en(rd_p), .framing_error(fe_p),
    .parity_error(pe_p), .overrun(ovr_p),
    .busy(busy_p)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // each tick: one idle cycle then one tick cycle
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b0;
      step();
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  // returns in the DONE cycle (just after the stop-sampling tick)
  task automatic send(input bit p, input logic [7:0] d,
                      input bit par_en, input bit par,
                      input bit stop, input bit odd);
    rx = d[0];
    if (p) start_p = 1'b1;
    else   start_n = 1'b1;
    step();
    start_p = 1'b0;
    start_n = 1'b0;
    for (int i = 1; i < 8; i++) begin
      rx = d[i];
      if (odd && i == 3) begin
        ticks(5);
        start_n = 1'b1;
        step();
        start_n = 1'b0;
        ticks(3);
        repeat (100) step();
        check("busy_gap", {31'd0, busy_n}, 32'd1);
        check("done_gap", {31'd0, done_n}, 32'd0);
        ticks(8);
      end else begin
        ticks(16);
      end
    end
    if (par_en) begin
      rx = par;
      ticks(16);
    end
    rx = stop;
    ticks(16);
    rx = 1'b1;
    if (p) check("done_p", {31'd0, done_p}, 32'd1);
    else   check("done_n", {31'd0, done_n}, 32'd1);
  endtask

  task automatic read_n();
    rd_n = 1'b1;
    step();
    rd_n = 1'b0;
  endtask

  task automatic read_p();
    rd_p = 1'b1;
    step();
    rd_p = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    tick    = 1'b0;
    rx      = 1'b1;
    start_n = 1'b0;
    start_p = 1'b0;
    rd_n    = 1'b0;
    rd_p    = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_byte", {24'd0, byte_n}, 32'h0);
    check("rst_valid", {31'd0, valid_n}, 32'd0);
    check("rst_busy", {31'd0, busy_n}, 32'd0);
    check("rst_done", {31'd0, done_n}, 32'd0);
    check("rst_ovr", {31'd0, ovr_n}, 32'd0);
    check("rst_pe_p", {31'd0, pe_p}, 32'd0);

    // 8N1 0xA5, good stop
    send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    check("lat_valid", {31'd0, valid_n}, 32'd0);
    check("done_busy", {31'd0, busy_n}, 32'd1);
    step();
    check("a5_byte", {24'd0, byte_n}, 32'hA5);
    check("a5_valid", {31'd0, valid_n}, 32'd1);
    check("a5_fe", {31'd0, fe_n}, 32'd0);
    check("a5_pe", {31'd0, pe_n}, 32'd0);
    check("a5_busy", {31'd0, busy_n}, 32'd0);
    check("a5_done", {31'd0, done_n}, 32'd0);
    read_n();
    check("a5_rd", {31'd0, valid_n}, 32'd0);

    // 0x3C with stop bit 0
    send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("3c_byte", {24'd0, byte_n}, 32'h3C);
    check("3c_fe", {31'd0, fe_n}, 32'd1);
    read_n();
    check("3c_rd_valid", {31'd0, valid_n}, 32'd0);
    check("3c_rd_fe", {31'd0, fe_n}, 32'd0);
    check("3c_rd_byte", {24'd0, byte_n}, 32'h3C);
    read_n();
    check("rd_idle", {31'd0, valid_n}, 32'd0);

    // even parity: 0x07 has three ones -> parity bit 1
    send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    check("par1_byte", {24'd0, byte_p}, 32'h07);
    check("par1_valid", {31'd0, valid_p}, 32'd1);
    check("par1_pe", {31'd0, pe_p}, 32'd0);
    check("par1_n_idle", {31'd0, valid_n}, 32'd0);
    read_p();
    send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check("par0_pe", {31'd0, pe_p}, 32'd1);
    read_p();
    check("par0_rd", {31'd0, pe_p}, 32'd0);

    // back-to-back without reading
    send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check("ovr_byte", {24'd0, byte_n}, 32'h22);
    check("ovr_set", {31'd0, ovr_n}, 32'd1);
    check("ovr_valid", {31'd0, valid_n}, 32'd1);
    read_n();
    check("ovr_clr", {31'd0, ovr_n}, 32'd0);

    // read coincides with the second DONE
    send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
    rd_n = 1'b1;
    step();
    rd_n = 1'b0;
    check("rdd_valid", {31'd0, valid_n}, 32'd1);
    check("rdd_ovr", {31'd0, ovr_n}, 32'd0);
    check("rdd_byte", {24'd0, byte_n}, 32'h22);

    // async reset after three data bits of 0xFF
    rx = 1'b1;
    start_n = 1'b1;
    step();
    start_n = 1'b0;
    ticks(32);
    check("mid_busy", {31'd0, busy_n}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_byte", {24'd0, byte_n}, 32'h0);
    check("ar_valid", {31'd0, valid_n}, 32'd0);
    check("ar_busy", {31'd0, busy_n}, 32'd0);
    check("ar_done", {31'd0, done_n}, 32'd0);
    step();
    reset = 1'b0;
    step();
    send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check("5a_byte", {24'd0, byte_n}, 32'h5A);
    check("5a_valid", {31'd0, valid_n}, 32'd1);
    check("5a_fe", {31'd0, fe_n}, 32'd0);
    read_n();

    // spurious start and a long tick gap inside frame 0x81
    send(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check("81_byte", {24'd0, byte_n}, 32'h81);
    check("81_valid", {31'd0, valid_n}, 32'd1);
    check("81_ovr", {31'd0, ovr_n}, 32'd0);
    check("81_busy", {31'd0, busy_n}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
